// File: rtl/viterbi_ctrl_pkg.sv
// Shared types and step-count helpers for the Viterbi frame controller.
`ifndef PARAM_DEF_SV
`include "param_def.sv"
`endif

package viterbi_ctrl_pkg;
    localparam int FRAME_W  = 384;
    localparam int STEPS_R2 = FRAME_W / 4;
    localparam int STEPS_R3 = FRAME_W / 6;
    localparam int CNT_W    = 7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        DECODE    = 3'd2,
        TRACEBACK = 3'd3,
        DONE      = 3'd4
    } ctrl_state_t;

    // Number of decode steps (symbol groups) in one frame at the given rate.
    function automatic logic [CNT_W-1:0] steps_for_rate(input logic rate,
                                                        input int r2,
                                                        input int r3);
        return (rate == `CODE_RATE_3) ? CNT_W'(r3) : CNT_W'(r2);
    endfunction
endpackage

// File: rtl/param_def.sv
// Code-rate encodings shared by the Viterbi front end.
`ifndef PARAM_DEF_SV
`define PARAM_DEF_SV
`define CODE_RATE_2 1'b0
`define CODE_RATE_3 1'b1
`endif

// File: rtl/viterbi_step_cnt.sv
// Loadable terminal-count counter: 'last' is high while the count equals
// the loaded limit.
module viterbi_step_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] limit,
    input  logic         en,
    output logic         last
);
    logic [W-1:0] cnt;
    logic [W-1:0] lim_q;

    // Terminal value is captured once per frame and held through decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      lim_q <= '0;
        else if (load) lim_q <= limit;
    end

    // Step counter: cleared on frame accept, advances once per decode step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + W'(1);
    end

    assign last = (cnt == lim_q);
endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame-level sequencer: accepts a frame, re-arms the slicer, enables one
// decode step per cycle for the rate-dependent step count, runs traceback
// and holds the result valid until downstream takes it.
`ifndef PARAM_DEF_SV
`include "param_def.sv"
`endif

import viterbi_ctrl_pkg::*;

module viterbi_frame_ctrl #(
    parameter int FRAME_W  = 384,
    parameter int STEPS_R2 = FRAME_W / 4,
    parameter int STEPS_R3 = FRAME_W / 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_frame_valid,
    output logic               o_frame_ready,
    input  logic [FRAME_W-1:0] i_data_frame,
    input  logic               i_code_rate,
    output logic [FRAME_W-1:0] o_data_frame,
    output logic               o_code_rate,
    output logic               o_slice_rst,
    output logic               o_en_s,
    output logic               o_en_acs,
    input  logic               i_ood,
    output logic               o_en_tb,
    input  logic               i_tb_done,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic               o_err
);
    ctrl_state_t      state;
    logic             accept;
    logic             step_last;
    logic [CNT_W-1:0] limit;

    assign accept = (state == IDLE) && i_frame_valid;

    // Terminal count is N-1 so DECODE spans exactly N cycles.
    assign limit = steps_for_rate(o_code_rate, STEPS_R2, STEPS_R3) - CNT_W'(1);

    viterbi_step_cnt #(.W(CNT_W)) u_step_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .load  (state == LOAD),
        .limit (limit),
        .en    (state == DECODE),
        .last  (step_last)
    );

    // Sequencer FSM plus the frame/rate buffer and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            o_data_frame <= '0;
            o_code_rate  <= `CODE_RATE_2;
            o_err        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_frame_valid) begin
                    o_data_frame <= i_data_frame;
                    o_code_rate  <= i_code_rate;
                    o_err        <= 1'b0;
                    state        <= LOAD;
                end
                LOAD: state <= DECODE;
                DECODE: begin
                    // Slicer end-of-frame must coincide with the last step;
                    // an early flag is recorded but never shortens decode.
                    if (i_ood != step_last) o_err <= 1'b1;
                    if (step_last)          state <= TRACEBACK;
                end
                TRACEBACK: if (i_tb_done)   state <= DONE;
                DONE:      if (i_out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Slicer re-arm is low in reset and for the single LOAD cycle.
    assign o_slice_rst   = rst & (state != LOAD);
    assign o_frame_ready = (state == IDLE);
    assign o_en_s        = (state == DECODE);
    assign o_en_acs      = (state == DECODE);
    assign o_en_tb       = (state == TRACEBACK);
    assign o_out_valid   = (state == DONE);
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl with a behavioural slicer that
// raises end-of-frame on the last symbol group.
module tb_viterbi_frame_ctrl;
    localparam int   FW = 384;
    localparam logic R2 = 1'b0;
    localparam logic R3 = 1'b1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_frame_valid = 1'b0;
    logic          o_frame_ready;
    logic [FW-1:0] i_data_frame = '0;
    logic          i_code_rate = R2;
    logic [FW-1:0] o_data_frame;
    logic          o_code_rate;
    logic          o_slice_rst;
    logic          o_en_s;
    logic          o_en_acs;
    logic          i_ood;
    logic          o_en_tb;
    logic          i_tb_done = 1'b0;
    logic          o_out_valid;
    logic          i_out_ready = 1'b0;
    logic          o_err;

    int n_vec = 0;
    int n_bad = 0;

    logic [FW-1:0] frm_a5;
    logic [FW-1:0] frm_3c;
    logic [8:0]    sc;
    logic          ood_inj = 1'b0;

    always #5 clk = ~clk;

    viterbi_frame_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .i_frame_valid (i_frame_valid),
        .o_frame_ready (o_frame_ready),
        .i_data_frame  (i_data_frame),
        .i_code_rate   (i_code_rate),
        .o_data_frame  (o_data_frame),
        .o_code_rate   (o_code_rate),
        .o_slice_rst   (o_slice_rst),
        .o_en_s        (o_en_s),
        .o_en_acs      (o_en_acs),
        .i_ood         (i_ood),
        .o_en_tb       (o_en_tb),
        .i_tb_done     (i_tb_done),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_err         (o_err)
    );

    // Slicer model: bit pointer starts at FW-1, consumes 4 or 6 bits per step.
    always @(posedge clk) begin
        if (!o_slice_rst)  sc <= 9'(FW - 1);
        else if (o_en_s)   sc <= sc - ((o_code_rate == R3) ? 9'd6 : 9'd4);
    end
    assign i_ood = ood_inj |
                   (o_en_s && (sc == ((o_code_rate == R3) ? 9'd5 : 9'd3)));

    task automatic chk(input string tag, input logic [FW-1:0] obs,
                       input logic [FW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One full frame, entered and left at a negedge in IDLE.
    task automatic do_frame(input logic [FW-1:0] frm, input logic rate,
                            input int n_exp, input logic err_exp,
                            input int inj_step, input int tb_wait,
                            input int hold);
        int n;
        int acs_bad;
        i_frame_valid = 1'b1;
        i_data_frame  = frm;
        i_code_rate   = rate;
        chk("ready_idle", o_frame_ready, 1);
        @(negedge clk);
        i_frame_valid = 1'b0;
        i_data_frame  = ~frm;
        i_code_rate   = ~rate;
        chk("load_srst", o_slice_rst, 0);
        chk("load_en_s", o_en_s, 0);
        chk("load_ready", o_frame_ready, 0);
        chk("frame_latch", o_data_frame, frm);
        chk("rate_latch", o_code_rate, rate);
        chk("err_clr", o_err, 0);
        @(negedge clk);
        chk("srst_rel", o_slice_rst, 1);
        n = 0;
        acs_bad = 0;
        while (o_en_s && n < 200) begin
            if (o_en_acs !== o_en_s) acs_bad++;
            ood_inj = (n == inj_step);
            n++;
            @(negedge clk);
        end
        ood_inj = 1'b0;
        chk("dec_len", n, n_exp);
        chk("acs_eq", acs_bad, 0);
        chk("err", o_err, err_exp);
        chk("en_tb", o_en_tb, 1);
        for (int i = 0; i < tb_wait; i++) begin
            @(negedge clk);
            chk("tb_hold", o_en_tb, 1);
        end
        i_tb_done = 1'b1;
        @(negedge clk);
        i_tb_done = 1'b0;
        chk("done_valid", o_out_valid, 1);
        chk("tb_off", o_en_tb, 0);
        for (int i = 0; i < hold; i++) begin
            i_frame_valid = 1'b1;
            i_data_frame  = frm_3c;
            i_code_rate   = ~rate;
            chk("hold_ready", o_frame_ready, 0);
            @(negedge clk);
            chk("hold_valid", o_out_valid, 1);
        end
        i_frame_valid = 1'b0;
        if (hold > 0) begin
            chk("no_latch", o_data_frame, frm);
            chk("no_rate", o_code_rate, rate);
            chk("err_sticky", o_err, err_exp);
        end
        i_out_ready = 1'b1;
        @(negedge clk);
        i_out_ready = 1'b0;
        chk("idle_back", o_frame_ready, 1);
        chk("valid_drop", o_out_valid, 0);
    endtask

    initial begin
        frm_a5 = {48{8'hA5}};
        frm_3c = {48{8'h3C}};

        // Reset state
        @(negedge clk);
        chk("rst_frame", o_data_frame, 0);
        chk("rst_rate", o_code_rate, R2);
        chk("rst_srst", o_slice_rst, 0);
        chk("rst_en_s", o_en_s, 0);
        chk("rst_en_tb", o_en_tb, 0);
        chk("rst_valid", o_out_valid, 0);
        chk("rst_err", o_err, 0);
        @(negedge clk);
        rst = 1'b1;
        // Stray traceback/ready pulses in IDLE are ignored
        i_tb_done = 1'b1;
        i_out_ready = 1'b1;
        @(negedge clk);
        i_tb_done = 1'b0;
        i_out_ready = 1'b0;
        chk("stray_idle", o_frame_ready, 1);
        chk("stray_en_tb", o_en_tb, 0);

        // Rate 1/2 and rate 1/3 nominal frames
        do_frame(frm_a5, R2, 96, 1'b0, -1, 2, 0);
        do_frame(frm_a5, R3, 64, 1'b0, -1, 0, 0);

        // Early end-of-frame at step 40: full length, sticky error,
        // downstream stalls 10 cycles while a new frame is offered
        do_frame(frm_a5, R2, 96, 1'b1, 40, 1, 10);
        chk("err_until_next", o_err, 1);

        // Reset mid-decode at step 30
        i_frame_valid = 1'b1;
        i_data_frame  = frm_3c;
        i_code_rate   = R2;
        @(negedge clk);
        i_frame_valid = 1'b0;
        @(negedge clk);
        repeat (30) @(negedge clk);
        chk("pre_rst_en", o_en_s, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_en_s", o_en_s, 0);
        chk("mid_rst_acs", o_en_acs, 0);
        chk("mid_rst_tb", o_en_tb, 0);
        chk("mid_rst_valid", o_out_valid, 0);
        chk("mid_rst_srst", o_slice_rst, 0);
        chk("mid_rst_frame", o_data_frame, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Back-to-back: traceback done in its first cycle, ready at once
        do_frame(frm_3c, R2, 96, 1'b0, -1, 0, 0);
        do_frame(frm_a5, R3, 64, 1'b0, -1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
